// File: rtl/inertial_integrator_cal.sv
// inertial_integrator_cal: saturating pitch integrator with complementary accel fusion
// and a runtime calibration FSM that averages 2^CAL_LOG samples to find sensor offsets.
module inertial_integrator_cal #(
  parameter int W = 16,
  parameter int INT_FRAC = 11,
  parameter int FUDGE = 327,
  parameter int ACC_SHIFT = 13,
  parameter int FUSION_STEP = 1024,
  parameter int CAL_LOG = 8,
  parameter logic [W-1:0] PTCH_RT_OFF_DEF = 16'h0050,
  parameter logic [W-1:0] AZ_OFF_DEF = 16'h00A0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                vld,
  input  logic signed [W-1:0] ptch_rt,
  input  logic signed [W-1:0] AZ,
  input  logic                cal_req,
  input  logic                fusion_en,
  output logic signed [W-1:0] ptch,
  output logic                ptch_vld,
  output logic                cal_busy,
  output logic                cal_done
);
  localparam int IW = W + INT_FRAC;
  localparam int AW = W + CAL_LOG;
  localparam logic signed [IW+1:0] FSTEP = (IW+2)'(FUSION_STEP);
  localparam logic signed [IW+1:0] MAXV = {3'b000, {(IW-1){1'b1}}};
  localparam logic signed [IW+1:0] MINV = {3'b111, {(IW-1){1'b0}}};
  typedef enum logic {RUN, CAL} state_t;
  state_t state_q, state_d;
  logic signed [IW-1:0] int_q, int_d, sat;
  logic signed [W-1:0] rt_off_q, rt_off_d, az_off_q, az_off_d, ptch_acc;
  logic signed [AW-1:0] acc_rt_q, acc_rt_d, acc_az_q, acc_az_d, acc_rt_nx, acc_az_nx;
  logic [CAL_LOG-1:0] cnt_q, cnt_d;
  logic ptch_vld_q, ptch_vld_d, cal_busy_q, cal_busy_d, cal_done_q, cal_done_d;
  logic signed [W:0] rt_comp, az_comp;
  logic signed [2*W+1:0] prod;
  logic signed [IW+1:0] corr, sum;
  assign ptch = int_q[IW-1:INT_FRAC];
  assign ptch_vld = ptch_vld_q;
  assign cal_busy = cal_busy_q;
  assign cal_done = cal_done_q;
  assign rt_comp = {ptch_rt[W-1], ptch_rt} - {rt_off_q[W-1], rt_off_q};
  assign az_comp = {AZ[W-1], AZ} - {az_off_q[W-1], az_off_q};
  assign prod = az_comp * $signed((W+1)'(FUDGE));
  assign ptch_acc = W'(prod >>> ACC_SHIFT);
  assign corr = !fusion_en ? '0 : (ptch_acc > ptch) ? FSTEP : -FSTEP;
  // Extra headroom bits let the sum be clamped instead of wrapping.
  assign sum = {{2{int_q[IW-1]}}, int_q} - {{(IW+1-W){rt_comp[W]}}, rt_comp} + corr;
  assign sat = (sum > MAXV) ? MAXV[IW-1:0] : (sum < MINV) ? MINV[IW-1:0] : sum[IW-1:0];
  assign acc_rt_nx = acc_rt_q + {{CAL_LOG{ptch_rt[W-1]}}, ptch_rt};
  assign acc_az_nx = acc_az_q + {{CAL_LOG{AZ[W-1]}}, AZ};
  always_comb begin
    state_d = state_q;
    int_d = int_q;
    rt_off_d = rt_off_q;
    az_off_d = az_off_q;
    acc_rt_d = acc_rt_q;
    acc_az_d = acc_az_q;
    cnt_d = cnt_q;
    ptch_vld_d = 1'b0;
    cal_done_d = 1'b0;
    if (state_q == RUN) begin
      int_d = vld ? sat : int_q;
      ptch_vld_d = vld;
      if (cal_req) begin
        state_d = CAL;
        acc_rt_d = '0;
        acc_az_d = '0;
        cnt_d = '0;
      end
    end else begin
      int_d = '0;
      if (vld) begin
        acc_rt_d = acc_rt_nx;
        acc_az_d = acc_az_nx;
        cnt_d = cnt_q + CAL_LOG'(1);
        if (cnt_q == '1) begin
          state_d = RUN;
          rt_off_d = W'(acc_rt_nx >>> CAL_LOG);
          az_off_d = W'(acc_az_nx >>> CAL_LOG);
          cal_done_d = 1'b1;
        end
      end
    end
    cal_busy_d = (state_d == CAL);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      int_q <= '0;
      rt_off_q <= PTCH_RT_OFF_DEF;
      az_off_q <= AZ_OFF_DEF;
      acc_rt_q <= '0;
      acc_az_q <= '0;
      cnt_q <= '0;
      ptch_vld_q <= 1'b0;
      cal_busy_q <= 1'b0;
      cal_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      int_q <= int_d;
      rt_off_q <= rt_off_d;
      az_off_q <= az_off_d;
      acc_rt_q <= acc_rt_d;
      acc_az_q <= acc_az_d;
      cnt_q <= cnt_d;
      ptch_vld_q <= ptch_vld_d;
      cal_busy_q <= cal_busy_d;
      cal_done_q <= cal_done_d;
    end
  end
endmodule

// File: tb/tb_inertial_integrator_cal.sv
// tb_inertial_integrator_cal: directed scenario tasks for the pitch integrator and calibration FSM.
module tb_inertial_integrator_cal;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vld = 1'b0;
  logic signed [15:0] ptch_rt = '0;
  logic signed [15:0] AZ = '0;
  logic cal_req = 1'b0;
  logic fusion_en = 1'b0;
  logic signed [15:0] ptch;
  logic ptch_vld, cal_busy, cal_done;
  int pass_cnt = 0;
  int tot = 0;

  inertial_integrator_cal dut (
    .clk(clk), .rst_n(rst_n), .vld(vld), .ptch_rt(ptch_rt), .AZ(AZ),
    .cal_req(cal_req), .fusion_en(fusion_en), .ptch(ptch), .ptch_vld(ptch_vld),
    .cal_busy(cal_busy), .cal_done(cal_done)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0;
    vld = 1'b0;
    cal_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic pulse();
    vld = 1'b1;
    @(posedge clk);
    #1 vld = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_defaults();
    ptch_rt = 16'h0050;
    AZ = 16'h00A0;
    fusion_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      pulse();
      tot++;
      if (ptch !== 16'h0000 || ptch_vld !== 1'b1) $display("FAIL default_vld%0d ptch=%h vld=%b want 0000/1", i, ptch, ptch_vld);
      else pass_cnt++;
      idle();
      tot++;
      if (ptch_vld !== 1'b0) $display("FAIL default_idle%0d ptch_vld=%b want 0", i, ptch_vld);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    tot++;
    if (ptch !== 16'h0000 || ptch_vld !== 1'b0 || cal_busy !== 1'b0 || cal_done !== 1'b0)
      $display("FAIL reset ptch=%h vld=%b busy=%b done=%b want 0000/0/0/0", ptch, ptch_vld, cal_busy, cal_done);
    else pass_cnt++;
    run_defaults();
  endtask

  task automatic test_gyro();
    do_reset();
    fusion_en = 1'b0;
    ptch_rt = 16'h0850;
    repeat (8) pulse();
    tot++;
    if (ptch !== 16'hFFF8) $display("FAIL gyro_8 ptch=%h want fff8", ptch);
    else pass_cnt++;
    repeat (8) pulse();
    tot++;
    if (ptch !== 16'hFFF0) $display("FAIL gyro_16 ptch=%h want fff0", ptch);
    else pass_cnt++;
  endtask

  task automatic test_fusion();
    do_reset();
    fusion_en = 1'b1;
    ptch_rt = 16'h0050;
    AZ = 16'h00A0;
    for (int i = 1; i <= 6; i++) begin
      pulse();
      tot++;
      if (ptch !== ((i % 2) ? 16'hFFFF : 16'h0000)) $display("FAIL fusion_%0d ptch=%h want %h", i, ptch, (i % 2) ? 16'hFFFF : 16'h0000);
      else pass_cnt++;
    end
  endtask

  task automatic test_cal();
    int bad = 0;
    do_reset();
    fusion_en = 1'b0;
    ptch_rt = 16'h0010;
    AZ = -16'sh0020;
    cal_req = 1'b1;
    idle();
    cal_req = 1'b0;
    tot++;
    if (cal_busy !== 1'b1 || ptch !== 16'h0000) $display("FAIL cal_entry busy=%b ptch=%h want 1/0000", cal_busy, ptch);
    else pass_cnt++;
    for (int i = 1; i < 256; i++) begin
      cal_req = (i == 100);
      pulse();
      cal_req = 1'b0;
      if (cal_busy !== 1'b1 || cal_done !== 1'b0 || ptch_vld !== 1'b0 || ptch !== 16'h0000) bad++;
    end
    tot++;
    if (bad != 0) $display("FAIL cal_busy_run bad_cycles=%0d want 0", bad);
    else pass_cnt++;
    pulse();
    tot++;
    if (cal_done !== 1'b1 || cal_busy !== 1'b0) $display("FAIL cal_done done=%b busy=%b want 1/0", cal_done, cal_busy);
    else pass_cnt++;
    idle();
    tot++;
    if (cal_done !== 1'b0) $display("FAIL cal_done_pulse done=%b want 0", cal_done);
    else pass_cnt++;
    bad = 0;
    repeat (50) begin
      pulse();
      if (ptch !== 16'h0000 || ptch_vld !== 1'b1) bad++;
    end
    tot++;
    if (bad != 0) $display("FAIL cal_rt_offset bad_samples=%0d want 0", bad);
    else pass_cnt++;
    fusion_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      pulse();
      tot++;
      if (ptch !== ((i % 2) ? 16'hFFFF : 16'h0000)) $display("FAIL cal_az_offset_%0d ptch=%h want %h", i, ptch, (i % 2) ? 16'hFFFF : 16'h0000);
      else pass_cnt++;
    end
  endtask

  task automatic test_sat();
    int neg = 0;
    int bad = 0;
    do_reset();
    fusion_en = 1'b0;
    ptch_rt = 16'sh8000;
    for (int i = 1; i <= 2100; i++) begin
      pulse();
      if (ptch[15] !== 1'b0) neg++;
      if (i >= 2044 && ptch !== 16'h7FFF) bad++;
      if (i == 2042) begin
        tot++;
        if (ptch !== 16'h7FEF) $display("FAIL sat_2042 ptch=%h want 7fef", ptch);
        else pass_cnt++;
      end
    end
    tot++;
    if (neg != 0) $display("FAIL sat_negative count=%0d want 0", neg);
    else pass_cnt++;
    tot++;
    if (bad != 0) $display("FAIL sat_hold bad_samples=%0d want 0", bad);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_cal();
    int bad = 0;
    do_reset();
    ptch_rt = 16'h0010;
    AZ = -16'sh0020;
    cal_req = 1'b1;
    idle();
    cal_req = 1'b0;
    repeat (100) pulse();
    tot++;
    if (cal_busy !== 1'b1) $display("FAIL midcal_busy busy=%b want 1", cal_busy);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    tot++;
    if (cal_busy !== 1'b0 || cal_done !== 1'b0) $display("FAIL midcal_async busy=%b done=%b want 0/0", cal_busy, cal_done);
    else pass_cnt++;
    repeat (3) begin
      idle();
      if (cal_done !== 1'b0 || cal_busy !== 1'b0) bad++;
    end
    rst_n = 1'b1;
    repeat (200) begin
      idle();
      if (cal_done !== 1'b0) bad++;
    end
    tot++;
    if (bad != 0) $display("FAIL midcal_no_done bad_cycles=%0d want 0", bad);
    else pass_cnt++;
    run_defaults();
  endtask

  initial begin
    test_reset();
    test_gyro();
    test_fusion();
    test_cal();
    test_sat();
    test_reset_mid_cal();
    $display("%0d/%0d checks passed", pass_cnt, tot);
    $finish;
  end
endmodule
